// File: rtl/sram_sp_be_rd_streamer_pkg.sv
`default_nettype none
// ============================================================================
// sram_sp_be_rd_streamer_pkg : FSM encodings and width helper for the streamer
// Revision: 1.0
// ============================================================================
package sram_sp_be_rd_streamer_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_READ  = 2'd1;
    localparam state_t ST_DRAIN = 2'd2;

    // Never returns 0 so that derived vectors always have at least one bit
    function automatic int func_log2(input int value);
        return (value > 1) ? $clog2(value) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_sc_reg_based.sv
`default_nettype none
// ============================================================================
// fifo_sc_reg_based : single-clock register FIFO, first-word-fall-through out
// Revision: 1.0
// ============================================================================
module fifo_sc_reg_based
    import sram_sp_be_rd_streamer_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int DATA_WD = 8,
    parameter int CNT_WD  = func_log2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               push,
    input  logic [DATA_WD-1:0] push_dat,
    input  logic               pop,
    output logic [DATA_WD-1:0] pop_dat,
    output logic [CNT_WD-1:0]  cnt,
    output logic               empty,
    output logic               full
);

    localparam int                PTR_WD   = func_log2(DEPTH);
    localparam logic [PTR_WD-1:0] PTR_LAST = PTR_WD'(DEPTH - 1);
    localparam logic [PTR_WD-1:0] PTR_ONE  = PTR_WD'(1);
    localparam logic [CNT_WD-1:0] CNT_FULL = CNT_WD'(DEPTH);
    localparam logic [CNT_WD-1:0] CNT_ONE  = CNT_WD'(1);

    logic [DATA_WD-1:0] mem [DEPTH];
    logic [PTR_WD-1:0]  wr_ptr;
    logic [PTR_WD-1:0]  rd_ptr;
    logic               do_push;
    logic               do_pop;

    assign empty   = (cnt == '0);
    assign full    = (cnt == CNT_FULL);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    // Head is forced to zero while empty so stale words never leak out
    assign pop_dat = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_dat;
                wr_ptr      <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + PTR_ONE;
            end
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + CNT_ONE;
                2'b01:   cnt <= cnt - CNT_ONE;
                default: cnt <= cnt;
            endcase
        end
    end

`ifdef SIM_KNOB_DBG
    always @(posedge clk) begin
        if (rstn && push && full && !pop) begin
            $error("fifo_sc_reg_based: push while full");
        end
    end
`endif

endmodule
`default_nettype wire

// File: rtl/sram_sp_be_rd_streamer.sv
`default_nettype none
// ============================================================================
// sram_sp_be_rd_streamer : sequential SRAM reader presented as a valid/ready
//                          stream, read latency absorbed by a credited FIFO
// Revision: 1.0
// ============================================================================
module sram_sp_be_rd_streamer
    import sram_sp_be_rd_streamer_pkg::*;
#(
    parameter int KNOB_REGOUT = -1,
    parameter int SIZE        = 8,
    parameter int DATA_WD     = 32,
    parameter int FIFO_DEPTH  = 4,
    parameter int SIZE_WD     = func_log2(SIZE)
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               start_i,
    input  logic [SIZE_WD-1:0] len_i,
    output logic               busy_o,
    output logic               done_o,
    output logic [SIZE_WD-1:0] sram_adr_o,
    output logic               sram_rd_val_o,
    input  logic               sram_rd_val_i,
    input  logic [DATA_WD-1:0] sram_rd_dat_i,
    output logic               out_val_o,
    input  logic               out_rdy_i,
    output logic [DATA_WD-1:0] out_dat_o,
    output logic               out_lst_o
);

    localparam int               CNT_WD  = func_log2(FIFO_DEPTH + 1);
    localparam int               OCC_WD  = ((CNT_WD > 2) ? CNT_WD : 2) + 1;
    localparam logic [SIZE_WD:0] LEN_MAX = (SIZE_WD + 1)'(SIZE);
    localparam logic [SIZE_WD:0] LEN_ONE = (SIZE_WD + 1)'(1);
    localparam logic [1:0]       INF_ONE = 2'd1;

    state_t              state;
    state_t              state_nxt;
    logic [SIZE_WD:0]    cnt_len_r;
    logic [SIZE_WD:0]    issue_cnt;
    logic [SIZE_WD:0]    out_cnt;
    logic [1:0]          inflight_cnt;
    logic [CNT_WD-1:0]   fifo_cnt;
    logic                fifo_empty;
    logic                fifo_full;
    logic [OCC_WD-1:0]   occupancy;
    logic                credit_ok;
    logic                issue;
    logic                start_acc;
    logic                rd_accept;
    logic                xfer;
    logic                last_issue;
    logic                drained;

    // Words held plus words still coming back must fit in the FIFO
    assign occupancy  = OCC_WD'(fifo_cnt) + OCC_WD'(inflight_cnt);
    assign credit_ok  = (occupancy < OCC_WD'(FIFO_DEPTH)) && !fifo_full;
    assign rd_accept  = sram_rd_val_i && (inflight_cnt != 2'd0);
    assign xfer       = out_val_o && out_rdy_i;
    assign last_issue = (issue_cnt == cnt_len_r - LEN_ONE);
    assign drained    = (inflight_cnt == 2'd0) && fifo_empty && (out_cnt == cnt_len_r);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (start_i)             state_nxt = ST_READ;
            ST_READ:  if (issue && last_issue) state_nxt = ST_DRAIN;
            ST_DRAIN: if (drained)             state_nxt = ST_IDLE;
            default:                           state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        busy_o    = (state != ST_IDLE);
        start_acc = (state == ST_IDLE) && start_i;
        issue     = (state == ST_READ) && credit_ok;
        done_o    = (state == ST_DRAIN) && drained;
    end

    assign sram_rd_val_o = issue;
    assign sram_adr_o    = (state == ST_READ) ? issue_cnt[SIZE_WD-1:0] : '0;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_len_r <= '0;
            issue_cnt <= '0;
            out_cnt   <= '0;
        end else if (start_acc) begin
            cnt_len_r <= (len_i == '0) ? LEN_MAX : {1'b0, len_i};
            issue_cnt <= '0;
            out_cnt   <= '0;
        end else begin
            if (issue) begin
                issue_cnt <= issue_cnt + LEN_ONE;
            end
            if (xfer) begin
                out_cnt <= out_cnt + LEN_ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            inflight_cnt <= '0;
        end else begin
            case ({issue, rd_accept})
                2'b10:   inflight_cnt <= inflight_cnt + INF_ONE;
                2'b01:   inflight_cnt <= inflight_cnt - INF_ONE;
                default: inflight_cnt <= inflight_cnt;
            endcase
        end
    end

    fifo_sc_reg_based #(
        .DEPTH   (FIFO_DEPTH),
        .DATA_WD (DATA_WD),
        .CNT_WD  (CNT_WD)
    ) u_fifo (
        .clk      (clk),
        .rstn     (rstn),
        .push     (rd_accept),
        .push_dat (sram_rd_dat_i),
        .pop      (out_rdy_i),
        .pop_dat  (out_dat_o),
        .cnt      (fifo_cnt),
        .empty    (fifo_empty),
        .full     (fifo_full)
    );

    assign out_val_o = !fifo_empty;
    assign out_lst_o = out_val_o && (out_cnt == cnt_len_r - LEN_ONE);

    if (KNOB_REGOUT < 0 || KNOB_REGOUT > 1 || FIFO_DEPTH < KNOB_REGOUT + 3) begin : g_knob_err
`ifdef SIM_KNOB_DBG
        always @(posedge clk) begin
            if (KNOB_REGOUT == -1) begin
                $error("sram_sp_be_rd_streamer: KNOB_REGOUT left at -1");
                $finish;
            end else begin
                $error("sram_sp_be_rd_streamer: FIFO_DEPTH below KNOB_REGOUT+3");
            end
        end
`endif
    end

endmodule
`default_nettype wire

// File: doc/sram_sp_be_rd_streamer.md
# sram_sp_be_rd_streamer

Read-side controller for the register-based single-port bit-enable SRAM. On a start pulse it drives the SRAM read port across a programmed number of consecutive addresses, starting at address 0. It absorbs the SRAM read latency (1 or 2 cycles, per KNOB_REGOUT) in a small credit-controlled FIFO and presents the words as a valid/ready stream with a last flag. It sits between an SRAM instance and a downstream consumer, and owns the SRAM address/read port while busy.

## Interface
- KNOB_REGOUT, -1, must match the attached SRAM; 0: SRAM read latency 1 cycle, 1: 2 cycles; -1 is illegal
- SIZE, -1, SRAM depth in words (power of two, ≥2)
- DATA_WD, -1, SRAM word width
- FIFO_DEPTH, 4, local FIFO depth; must be ≥ KNOB_REGOUT+3
- SIZE_WD (derived), `FUNC_LOG2(SIZE)
- clk  in  1  clock
- rstn  in  1  reset, asynchronous, active-low
- start_i  in  1  start pulse; sampled only in IDLE
- len_i  in  SIZE_WD  word count captured with start_i; 0 means SIZE
- busy_o  out  1  high from cycle after accepted start until done_o cycle inclusive
- done_o  out  1  one-cycle pulse after the last output handshake
- sram_adr_o  out  SIZE_WD  SRAM address
- sram_rd_val_o  out  1  SRAM read request
- sram_rd_val_i  in  1  SRAM read-data valid
- sram_rd_dat_i  in  DATA_WD  SRAM read data
- out_val_o  out  1  stream valid
- out_rdy_i  in  1  stream ready
- out_dat_o  out  DATA_WD  stream data
- out_lst_o  out  1  marks the final word of the run

## Operation
- FSM IDLE→READ→DRAIN→IDLE.
  - IDLE: start_i=1 → capture len (0→SIZE) into cnt_len_r (SIZE_WD+1 bits), clear counters, go READ.
  - READ: issue one read per cycle when credit allows.
    - sram_adr_o = issue counter; issue counter is SIZE_WD+1 bits, compared against cnt_len_r.
    - After the len-th issue, go DRAIN.
  - DRAIN: wait until in-flight = 0, FIFO empty, and the last handshake has occurred; then pulse done_o, go IDLE.
- Credit rule: issue only if fifo_cnt + inflight_cnt < FIFO_DEPTH.
  - inflight_cnt (2 bits): +1 on issue, −1 on sram_rd_val_i; both in the same cycle → unchanged.
  - Guarantees no FIFO overflow regardless of out_rdy_i.
- sram_rd_val_i pushes sram_rd_dat_i into the FIFO.
  - FIFO is first-word-fall-through, registered: data written at cycle N is visible on out_* at N+1.
- Handshake: a transfer occurs when out_val_o & out_rdy_i.
  - While out_val_o=1 and out_rdy_i=0, out_dat_o and out_lst_o are held stable.
- Output counter (SIZE_WD+1 bits) counts transfers. out_lst_o = out_val_o & (output counter == cnt_len_r−1).
- start_i outside IDLE: ignored; no state change.
- sram_rd_val_i with inflight_cnt=0: ignored.
- Reset, including mid-run: all state cleared to IDLE, FIFO emptied, in-flight data discarded.
- Reset values: busy_o=0, done_o=0, sram_rd_val_o=0, sram_adr_o=0, out_val_o=0, out_dat_o=0, out_lst_o=0.
- Only addresses 0..len−1 are ever driven; no address wrap.

## Timing
- start_i at cycle T:
  - busy_o and first sram_rd_val_o (adr 0) at T+1.
  - Data returns at T+2 (REGOUT=0) or T+3 (REGOUT=1).
  - First out_val_o at T+3 or T+4 respectively.
- Throughput: with out_rdy_i held 1, one word per cycle sustained, no bubbles, for either KNOB_REGOUT.
- Last transfer at cycle L → done_o=1 and busy_o=1 at L+1; busy_o=0 at L+2.
  - A new start_i is accepted at L+2 at the earliest.
- Run of len words, rdy=1: done_o at T+len+3 (REGOUT=0) or T+len+4 (REGOUT=1).

## Structure
- SIZE_WD via `FUNC_LOG2 from define.vh; the shared header also holds the FSM state encodings (IDLE=0, READ=1, DRAIN=2) as localparams-by-define.
- One sub-module: fifo_sc_reg_based.
  - Synchronous single-clock FIFO, parameters DEPTH and DATA_WD.
  - Outputs: count, first-word-fall-through output, empty/full.
  - Reusable elsewhere.
- Under SIM_KNOB_DBG:
  - Error and $finish if KNOB_REGOUT==−1.
  - Error if FIFO_DEPTH < KNOB_REGOUT+3.
  - Error on FIFO push while full.

## Test plan
- SIZE=8, REGOUT=0, len=0, rdy=1, SRAM preloaded with words 0x10..0x17 → eight transfers 0x10..0x17 on consecutive cycles from T+3, out_lst_o on 0x17, done_o at T+11.
- REGOUT=1, len=5, rdy=1 → five back-to-back words from T+4, no bubble, done_o at T+9.
- REGOUT=1, len=8, rdy toggling 1/0 each cycle plus a 6-cycle stall → data in order and held stable during stalls, at most 4 words in the FIFO, no overflow, out_lst_o only on word 7.
- start_i repeated at T+2 and T+5 during a len=4 run → ignored; exactly 4 transfers and one done_o.
- rstn asserted at T+4 of a len=8 run → all outputs 0 immediately. After release, a fresh start with len=2 yields exactly words 0 and 1, with no stale data.
- len=1 → single word with out_lst_o=1. Then back-to-back start at the first cycle busy_o=0 → accepted.
